// File: rtl/gray_accumulator.sv
// gray_accumulator: sums a framed stream of gray-coded operands and returns the gray-coded total
module gray_accumulator #(
    parameter int WIDTH = 4,
    parameter int FRAME_LEN = 4,
    localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx, in_bin;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic ovf, ovf_nx;
    logic [WIDTH:0] sum;
    always_comb begin
        in_bin = '0;
        for (int i = 0; i < WIDTH; i++) in_bin[i] = ^(in_gray >> i);
    end
    assign sum = {1'b0, acc} + {1'b0, in_bin};
    assign in_ready = rst_n && state == ACCUM;
    assign out_valid = state == HOLD;
    assign out_sum = acc ^ (acc >> 1);
    assign out_co = ovf;
    assign out_count = cnt;
    always_comb begin
        state_nx = state;
        acc_nx = acc;
        ovf_nx = ovf;
        cnt_nx = cnt;
        if (state == ACCUM) begin
            if (in_valid) begin
                acc_nx = sum[WIDTH-1:0];
                ovf_nx = ovf | sum[WIDTH];
                cnt_nx = cnt + 1'b1;
                state_nx = (in_last || cnt == CNT_W'(FRAME_LEN - 1)) ? HOLD : ACCUM;
            end
        end else if (out_ready) begin
            acc_nx = '0;
            ovf_nx = 1'b0;
            cnt_nx = '0;
            state_nx = ACCUM;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            acc <= acc_nx;
            ovf <= ovf_nx;
            cnt <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_gray_accumulator.sv
// tb_gray_accumulator: directed checks of framing, wrap, backpressure, stall and reset behaviour
module tb_gray_accumulator;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_co;
    logic [3:0] in_gray, out_sum;
    logic [2:0] out_count;
    int errors = 0;
    int checks = 0;

    gray_accumulator #(.WIDTH(4), .FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_gray(in_gray), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] g, input logic l);
        in_valid = 1'b1;
        in_gray = g;
        in_last = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic result(input string tag, input logic [3:0] s, input logic c, input logic [2:0] n);
        check({tag, "_valid"}, 16'(out_valid), 16'd1);
        check({tag, "_ready"}, 16'(in_ready), 16'd0);
        check({tag, "_sum"}, 16'(out_sum), 16'(s));
        check({tag, "_co"}, 16'(out_co), 16'(c));
        check({tag, "_count"}, 16'(out_count), 16'(n));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_drain_ready"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_gray = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_ready", 16'(in_ready), 16'd0);
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_sum", 16'(out_sum), 16'd0);
        check("rst_co", 16'(out_co), 16'd0);
        check("rst_count", 16'(out_count), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        // short frame: 3+5+7 = 15 -> gray 1000
        send(4'b0010, 1'b0);
        send(4'b0111, 1'b0);
        check("short_mid_valid", 16'(out_valid), 16'd0);
        send(4'b0100, 1'b1);
        result("short", 4'b1000, 1'b0, 3'd3);
        consume("short");
        // wrap: 15+1 = 16 -> 0 with carry
        send(4'b1000, 1'b0);
        send(4'b0001, 1'b1);
        result("wrap", 4'b0000, 1'b1, 3'd2);
        consume("wrap");
        // full frame: 8 four times, two wraps
        repeat (3) send(4'b1100, 1'b0);
        check("full_mid_valid", 16'(out_valid), 16'd0);
        send(4'b1100, 1'b0);
        result("full", 4'b0000, 1'b1, 3'd4);
        in_valid = 1'b1;
        in_gray = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            result("bp", 4'b0000, 1'b1, 3'd4);
        end
        in_valid = 1'b0;
        consume("bp");
        send(4'b0001, 1'b1);
        result("clear", 4'b0001, 1'b0, 3'd1);
        consume("clear");
        // in_last on the 4th operand: 1+1+1+1 = 4 -> gray 0110
        repeat (3) send(4'b0001, 1'b0);
        send(4'b0001, 1'b1);
        result("last4", 4'b0110, 1'b0, 3'd4);
        consume("last4");
        // upstream stall with out_ready held high in ACCUM: 1+2 = 3 -> gray 0010
        out_ready = 1'b1;
        send(4'b0001, 1'b0);
        in_gray = 4'b1111;
        in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_last = 1'b0;
        check("stall_valid", 16'(out_valid), 16'd0);
        check("stall_count", 16'(out_count), 16'd1);
        out_ready = 1'b0;
        send(4'b0011, 1'b1);
        result("stall", 4'b0010, 1'b0, 3'd2);
        consume("stall");
        // reset mid-frame: partial sum 12 is discarded
        send(4'b0111, 1'b0);
        send(4'b0100, 1'b0);
        check("pre_rst_sum", 16'(out_sum), 16'(4'b1010));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 16'(out_valid), 16'd0);
        check("mid_rst_sum", 16'(out_sum), 16'd0);
        check("mid_rst_count", 16'(out_count), 16'd0);
        check("mid_rst_ready", 16'(in_ready), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        send(4'b0010, 1'b1);
        result("post_rst", 4'b0010, 1'b0, 3'd1);
        consume("post_rst");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
